tt_um_blink_pwm_schoeberl: RTL

//  Tiny Tapeout user-project top: successor to the single-LED hello blinker.

---
 rtl/tt_blink_pkg.sv | 14 +
 rtl/tt_tick_prescaler.sv | 30 +++
 rtl/tt_um_blink_pwm_schoeberl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/tt_blink_pkg.sv
// Shared mode encoding and widths for the blink/PWM Tiny Tapeout project.
package tt_blink_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_PWM   = 2'd1,
    MODE_SCAN  = 2'd2,
    MODE_HOLD  = 2'd3
  } mode_t;

  localparam int DUTY_W = 4;
  localparam int TICK_W = 8;

endpackage

// File: rtl/tt_tick_prescaler.sv
// Free-running tick generator: counts 0..PRESCALE-1 while enabled and pulses
// tick for one cycle on the wrap; clr restarts the count from zero.
module tt_tick_prescaler #(
  parameter int PRESCALE = 12_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && !clr && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tt_um_blink_pwm_schoeberl.sv
// LED pattern generator (count / PWM / scan / hold) under the Tiny Tapeout harness.
// Optional TT_PWM_DUTY_LOAD_EN adds per-channel duty registers loaded via uio_in.
module tt_um_blink_pwm_schoeberl #(
  parameter int PRESCALE = 12_500_000,
  parameter int CHANNELS = 8
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  import tt_blink_pkg::*;

  localparam logic [2:0] LAST_POS = 3'(CHANNELS - 1);

  logic [7:0]        ui_q;
  mode_t             mode_q;
  mode_t             mode_in;
  logic [TICK_W-1:0] tick_cnt;
  logic [DUTY_W-1:0] pwm_cnt;
  logic [2:0]        pos;
  logic [2:0]        pos_next;
  logic              dir_down;
  logic              dir_next;
  logic              mode_change;
  logic              run;
  logic              tick;
  logic [7:0]        pattern;

  assign mode_in     = mode_t'(ui_q[1:0]);
  assign mode_change = ena && (mode_in != mode_q);
  assign run         = ena && !mode_change && (mode_q != MODE_HOLD);

  tt_tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (run),
    .clr  (mode_change),
    .tick (tick)
  );

`ifdef TT_PWM_DUTY_LOAD_EN
  localparam logic [3:0] CH_LIMIT = 4'(CHANNELS);

  logic [DUTY_W-1:0] duty [8];
  logic [3:0]        sync1;
  logic [3:0]        sync2;
  logic              strobe_q;
  logic [2:0]        chan;
  logic              wr;
  logic              unused_in;

  assign chan      = sync2[2:0];
  assign wr        = ena && sync2[3] && !strobe_q;
  assign uio_oe    = 8'hF0;
  assign unused_in = &{1'b0, ui_q[3:2], uio_in[7:4]};

  // Strobe and address share the synchroniser; slots >= CHANNELS never load, so they read back 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      strobe_q <= 1'b0;
      uio_out  <= '0;
      for (int i = 0; i < 8; i++) duty[i] <= '0;
    end else begin
      sync1    <= uio_in[3:0];
      sync2    <= sync1;
      strobe_q <= sync2[3];
      if (wr && ({1'b0, chan} < CH_LIMIT)) duty[chan] <= ui_q[7:4];
      if (ena) uio_out <= {duty[chan], 4'b0000};
    end
  end
`else
  logic unused_in;

  assign uio_out   = 8'h00;
  assign uio_oe    = 8'h00;
  assign unused_in = &{1'b0, ui_q[3:2], uio_in};
`endif

  // Bounce without repeating the end positions.
  always_comb begin
    pos_next = pos;
    dir_next = dir_down;
    if (CHANNELS > 1) begin
      if (!dir_down) begin
        if (pos == LAST_POS) begin
          pos_next = pos - 1'b1;
          dir_next = 1'b1;
        end else begin
          pos_next = pos + 1'b1;
        end
      end else begin
        if (pos == 3'd0) begin
          pos_next = pos + 1'b1;
          dir_next = 1'b0;
        end else begin
          pos_next = pos - 1'b1;
        end
      end
    end
  end

  always_comb begin
    pattern = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < CHANNELS) begin
        case (mode_q)
          MODE_COUNT: pattern[i] = tick_cnt[i];
`ifdef TT_PWM_DUTY_LOAD_EN
          MODE_PWM:   pattern[i] = (pwm_cnt < duty[i]);
`else
          MODE_PWM:   pattern[i] = (pwm_cnt < ui_q[7:4]);
`endif
          MODE_SCAN:  pattern[i] = (pos == 3'(i));
          default:    pattern[i] = 1'b0;
        endcase
      end
    end
  end

  // A mode change restarts every pattern; the output follows from the new mode a cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ui_q     <= '0;
      mode_q   <= MODE_COUNT;
      tick_cnt <= '0;
      pwm_cnt  <= '0;
      pos      <= '0;
      dir_down <= 1'b0;
      uo_out   <= '0;
    end else begin
      ui_q <= ui_in;
      if (mode_change) begin
        mode_q   <= mode_in;
        tick_cnt <= '0;
        pwm_cnt  <= '0;
        pos      <= '0;
        dir_down <= 1'b0;
      end else if (run) begin
        if (mode_q == MODE_COUNT && tick) tick_cnt <= tick_cnt + 1'b1;
        if (mode_q == MODE_PWM) pwm_cnt <= pwm_cnt + 1'b1;
        if (mode_q == MODE_SCAN && tick) begin
          pos      <= pos_next;
          dir_down <= dir_next;
        end
      end
      if (ena && mode_q != MODE_HOLD) uo_out <= pattern;
    end
  end

endmodule
